// File: rtl/bs_cat_flush_if.sv
// ----------------------------------------------------------------------------
// bs_cat_flush_if : fragment-in / packed-word-out handshake bundle  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

interface bs_cat_flush_if #(
  parameter int DATA_WD = 32
);
  localparam int NUMB_WD = $clog2(DATA_WD);
  localparam int BYTE_WD = $clog2(DATA_WD / 8);

  logic               val_i;
  logic               rdy_o;
  logic [DATA_WD-1:0] dat_i;
  logic [NUMB_WD-1:0] numb_i;
  logic               flush_i;
  logic               val_o;
  logic               rdy_i;
  logic [DATA_WD-1:0] dat_o;
  logic               last_o;
  logic [BYTE_WD-1:0] byte_o;

  modport master (
    output val_i, dat_i, numb_i, flush_i, rdy_i,
    input  rdy_o, val_o, dat_o, last_o, byte_o
  );

  modport slave (
    input  val_i, dat_i, numb_i, flush_i, rdy_i,
    output rdy_o, val_o, dat_o, last_o, byte_o
  );
endinterface

`default_nettype wire

// File: rtl/bs_cat_flush.sv
// ----------------------------------------------------------------------------
// bs_cat_flush : LSB-first bit-fragment packer with byte-padded flush  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module bs_cat_flush #(
  parameter int DATA_WD = 32
) (
  input  logic          clk,
  input  logic          rst,
  bs_cat_flush_if.slave bus
);
  localparam int NUMB_WD = $clog2(DATA_WD);
  localparam int BYTE_WD = $clog2(DATA_WD / 8);
  localparam int FIL_WD  = NUMB_WD + 1;
  localparam int SUM_WD  = FIL_WD + 1;
  localparam int ACC_WD  = 2 * DATA_WD;
  localparam logic [FIL_WD-1:0] WORD_FIL = FIL_WD'(DATA_WD);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    FLSH = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_WD-1:0]   acc_q, acc_d;
  logic [FIL_WD-1:0]   fil_q, fil_d;
  logic                val_q, val_d;
  logic [DATA_WD-1:0]  dat_q, dat_d;
  logic                last_q, last_d;
  logic [BYTE_WD-1:0]  byte_q, byte_d;

  logic                rdy_w;
  logic                accept_w;
  logic                out_free_w;
  logic                flushing_w;
  logic                emit_w;
  logic [FIL_WD-1:0]   len_w;
  logic [DATA_WD-1:0]  mask_w;
  logic [ACC_WD-1:0]   frag_w;
  logic [ACC_WD-1:0]   acc_acc_w;
  logic [FIL_WD-1:0]   fil_acc_w;

  // Ready depends on registered state only, so no val_i/rdy_i -> rdy_o path.
  assign rdy_w      = (state_q == RUN) && (fil_q < WORD_FIL);
  assign accept_w   = bus.val_i && rdy_w;
  assign out_free_w = !val_q || bus.rdy_i;

  assign len_w  = (bus.numb_i == '0) ? WORD_FIL : {1'b0, bus.numb_i};
  assign mask_w = {DATA_WD{1'b1}} >> (WORD_FIL - len_w);
  assign frag_w = ACC_WD'(bus.dat_i & mask_w) << fil_q;

  always_comb begin
    acc_acc_w = acc_q;
    fil_acc_w = fil_q;
    if (accept_w) begin
      acc_acc_w = acc_q | frag_w;
      fil_acc_w = fil_q + len_w;
    end
  end

  // Once flushing, any leftover bits go out as a zero-padded final word.
  assign flushing_w = (state_q == FLSH) || (accept_w && bus.flush_i);
  assign emit_w     = out_free_w &&
                      ((fil_acc_w >= WORD_FIL) || (flushing_w && (fil_acc_w != '0)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_acc_w;
    fil_d   = fil_acc_w;
    val_d   = val_q && !bus.rdy_i;
    dat_d   = dat_q;
    last_d  = last_q;
    byte_d  = byte_q;

    if (val_q && bus.rdy_i) begin
      last_d = 1'b0;
      byte_d = '0;
    end

    if (emit_w) begin
      val_d  = 1'b1;
      dat_d  = acc_acc_w[DATA_WD-1:0];
      acc_d  = acc_acc_w >> DATA_WD;
      fil_d  = (fil_acc_w >= WORD_FIL) ? (fil_acc_w - WORD_FIL) : '0;
      last_d = flushing_w && (fil_acc_w <= WORD_FIL);
      byte_d = '0;
      if (flushing_w && (fil_acc_w <= WORD_FIL)) begin
        // ceil(fill/8) wraps to 0 for a completely full final word.
        byte_d = BYTE_WD'((SUM_WD'(fil_acc_w) + SUM_WD'(7)) >> 3);
      end
    end

    case (state_q)
      RUN: begin
        if (accept_w && bus.flush_i) begin
          state_d = FLSH;
        end
      end
      FLSH: begin
        if (val_q && bus.rdy_i && last_q) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      acc_q   <= '0;
      fil_q   <= '0;
      val_q   <= 1'b0;
      dat_q   <= '0;
      last_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fil_q   <= fil_d;
      val_q   <= val_d;
      dat_q   <= dat_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
    end
  end

  assign bus.rdy_o  = rdy_w;
  assign bus.val_o  = val_q;
  assign bus.dat_o  = dat_q;
  assign bus.last_o = last_q;
  assign bus.byte_o = byte_q;

endmodule

`default_nettype wire

// File: tb/tb_bs_cat_flush.sv
// ----------------------------------------------------------------------------
// tb_bs_cat_flush : directed + randomized bench with bit-queue reference model
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bs_cat_flush;
  localparam int DATA_WD = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   rnd_rdy = 1'b0;

  always #5 clk = ~clk;

  bs_cat_flush_if #(.DATA_WD(DATA_WD)) bus ();

  bs_cat_flush #(.DATA_WD(DATA_WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  b;
  } wrd_t;

  bit   bq[$];
  wrd_t exq[$];
  bit   in_flush = 1'b0;
  bit   stall = 1'b0;
  logic [31:0] hold_dat;
  logic        hold_last;
  logic [1:0]  hold_byte;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: bits form one LSB-first stream; words are cut every 32 bits,
  // a flush pads the tail to a byte boundary and tags the final word.
  function automatic void model_accept(input logic [31:0] d, input logic [4:0] nb, input logic f);
    int   n;
    wrd_t w;
    n = (nb == 0) ? 32 : int'(nb);
    for (int i = 0; i < n; i++) bq.push_back(d[i]);
    while (bq.size() >= 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w.d[i] = bq.pop_front();
      exq.push_back(w);
    end
    if (f) begin
      if (bq.size() == 0) begin
        w = exq.pop_back();
        w.l = 1'b1;
        w.b = 2'd0;
        exq.push_back(w);
      end else begin
        int r;
        r = bq.size();
        w = '0;
        for (int i = 0; i < r; i++) w.d[i] = bq.pop_front();
        w.l = 1'b1;
        w.b = 2'(((r + 7) / 8) % 4);
        exq.push_back(w);
      end
      in_flush = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      bq.delete();
      exq.delete();
      in_flush = 1'b0;
      stall    = 1'b0;
    end else begin
      if (in_flush) chk("rdy_low_in_flush", bus.rdy_o, 1'b0);
      if (stall) begin
        chk("hold_val", bus.val_o, 1'b1);
        chk("hold_dat", bus.dat_o, hold_dat);
        chk("hold_last", bus.last_o, hold_last);
        chk("hold_byte", bus.byte_o, hold_byte);
      end
      if (bus.val_i && bus.rdy_o) model_accept(bus.dat_i, bus.numb_i, bus.flush_i);
      if (bus.val_o && bus.rdy_i) begin
        chk("word_expected", exq.size() != 0, 1'b1);
        if (exq.size() != 0) begin
          wrd_t e;
          e = exq.pop_front();
          chk("word_dat", bus.dat_o, e.d);
          chk("word_last", bus.last_o, e.l);
          if (e.l) begin
            chk("word_byte", bus.byte_o, e.b);
            in_flush = 1'b0;
          end
        end
      end
      stall     = bus.val_o && !bus.rdy_i;
      hold_dat  = bus.dat_o;
      hold_last = bus.last_o;
      hold_byte = bus.byte_o;
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] n, input logic f, output int waits);
    bit acc;
    waits = 0;
    bus.val_i = 1'b1;
    bus.dat_i = d;
    bus.numb_i = n;
    bus.flush_i = f;
    forever begin
      @(negedge clk);
      acc = bus.rdy_o;
      @(posedge clk);
      #1;
      if (rnd_rdy) bus.rdy_i = ($urandom_range(0, 3) != 0);
      if (acc || waits >= 200) break;
      waits++;
    end
    chk("send_timeout", waits < 200, 1'b1);
    bus.val_i = 1'b0;
    bus.dat_i = $urandom;
    bus.flush_i = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exq.size() != 0 || bus.val_o) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_timeout", t < 300, 1'b1);
    chk("drain_empty", exq.size(), 0);
  endtask

  initial begin
    int w;
    logic [31:0] w1, w2, w3;
    rst = 1'b1;
    bus.val_i = 1'b0;
    bus.dat_i = '0;
    bus.numb_i = '0;
    bus.flush_i = 1'b0;
    bus.rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_val", bus.val_o, 1'b0);
    chk("rst_dat", bus.dat_o, 32'h0);
    chk("rst_last", bus.last_o, 1'b0);
    chk("rst_byte", bus.byte_o, 2'd0);
    chk("rst_rdy", bus.rdy_o, 1'b1);

    // Four bytes pack into one word.
    send({$urandom_range(0, 16'hffff), 8'h00, 8'h11} | 32'h0, 5'd8, 1'b0, w);
    send(32'hffffff22 & {24'($urandom), 8'h22}, 5'd8, 1'b0, w);
    send(32'h00000033, 5'd8, 1'b0, w);
    send(32'h00000044, 5'd8, 1'b0, w);
    chk("b4_val", bus.val_o, 1'b1);
    chk("b4_dat", bus.dat_o, 32'h44332211);
    chk("b4_last", bus.last_o, 1'b0);
    @(posedge clk);
    #1;

    // Full-width streaming at one word per cycle.
    for (int i = 0; i < 8; i++) begin
      send(32'hDEADBEEF, 5'd0, 1'b0, w);
      chk("full_nowait", w, 0);
      chk("full_dat", bus.dat_o, 32'hDEADBEEF);
    end
    drain();

    // Tiny flushed stream.
    send(32'h00000005, 5'd3, 1'b1, w);
    chk("f3_dat", bus.dat_o, 32'h5);
    chk("f3_last", bus.last_o, 1'b1);
    chk("f3_byte", bus.byte_o, 2'd1);
    chk("f3_rdy_busy", bus.rdy_o, 1'b0);
    @(posedge clk);
    #1;
    chk("f3_rdy_back", bus.rdy_o, 1'b1);

    // Flush spilling across a word boundary, with garbage above the counts.
    send({12'($urandom), 20'hABCDE}, 5'd20, 1'b0, w);
    send({12'($urandom), 20'h12345}, 5'd20, 1'b1, w);
    chk("f40_dat0", bus.dat_o, 32'h345ABCDE);
    chk("f40_last0", bus.last_o, 1'b0);
    @(posedge clk);
    #1;
    chk("f40_dat1", bus.dat_o, 32'h00000012);
    chk("f40_last1", bus.last_o, 1'b1);
    chk("f40_byte1", bus.byte_o, 2'd1);
    drain();

    // Downstream stall with backpressure.
    w1 = $urandom; w2 = $urandom; w3 = $urandom;
    bus.rdy_i = 1'b0;
    send(w1, 5'd0, 1'b0, w);
    send(w2, 5'd0, 1'b0, w);
    bus.val_i = 1'b1;
    bus.dat_i = w3;
    bus.numb_i = 5'd0;
    bus.flush_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stall_rdy", bus.rdy_o, 1'b0);
      chk("stall_dat", bus.dat_o, w1);
    end
    @(posedge clk);
    #1;
    bus.rdy_i = 1'b1;
    send(w3, 5'd0, 1'b0, w);
    drain();

    // Randomized fragments, flushes and backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 120; i++) begin
      send($urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 7) == 0, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        bus.rdy_i = ($urandom_range(0, 3) != 0);
      end
    end
    rnd_rdy = 1'b0;
    bus.rdy_i = 1'b1;
    send($urandom, 5'd5, 1'b1, w);
    drain();

    // Reset while a flushed word is held.
    bus.rdy_i = 1'b0;
    send(32'h0000005A, 5'd8, 1'b1, w);
    chk("rf_held", bus.val_o, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rf_val", bus.val_o, 1'b0);
    chk("rf_rdy", bus.rdy_o, 1'b1);
    bus.rdy_i = 1'b1;
    send({24'($urandom), 8'hA5}, 5'd8, 1'b1, w);
    chk("rf_dat", bus.dat_o, 32'h000000A5);
    chk("rf_last", bus.last_o, 1'b1);
    chk("rf_byte", bus.byte_o, 2'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/bs_cat_flush.md
BS_CAT_FLUSH -- requirements
Module: bs_cat_flush

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, meaning packed word width in bits; legal values 16, 32, 64.
REQ-002 SHALL derive localparam NUMB_WD = clog2(DATA_WD), default 5, meaning width of the bit-count field.
REQ-003 SHALL derive localparam BYTE_WD = clog2(DATA_WD/8), default 2, meaning width of the final-word byte-count field.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 val_i  input  1  input fragment valid.
REQ-007 rdy_o  output  1  block can accept a fragment this cycle.
REQ-008 dat_i  input  DATA_WD  fragment bits, LSB-aligned.
REQ-009 numb_i  input  NUMB_WD  valid LSB count; 0 means DATA_WD bits, k means k bits; bits above the count are ignored.
REQ-010 flush_i  input  1  qualified by val_i; this fragment is the last of a stream.
REQ-011 val_o  output  1  packed word valid.
REQ-012 rdy_i  input  1  downstream accepts the word this cycle.
REQ-013 dat_o  output  DATA_WD  packed word, first-received bit at bit 0.
REQ-014 last_o  output  1  dat_o is the final word of a flushed stream.
REQ-015 byte_o  output  BYTE_WD  valid bytes in the final word; 0 means all DATA_WD/8 bytes; meaningful only when last_o=1.

Function
REQ-016 Input handshake: a fragment is accepted when val_i=1 and rdy_o=1; no other input is sampled.
REQ-017 Output handshake: a word transfers when val_o=1 and rdy_i=1; while val_o=1 and rdy_i=0, dat_o, last_o and byte_o SHALL hold stable.
REQ-018 Storage: a 2*DATA_WD accumulator acc plus a fill count fil (0..2*DATA_WD-1).
REQ-019 Packing is LSB-first (deflate order): an accepted fragment of n bits is ORed into acc at bit position fil, and fil becomes fil+n.
REQ-020 Emit rule: when the post-accept fill is >= DATA_WD and the output register is free, load acc[DATA_WD-1:0] into dat_o.
REQ-021 On emit, shift acc right by DATA_WD and reduce fil by DATA_WD, in the same cycle as the accept.
REQ-022 The output register is free when val_o=0 or rdy_i=1.
REQ-023 Latency: a word appears at dat_o in the cycle after the accept that completes it.
REQ-024 Throughput: one full-width fragment per cycle is sustained while rdy_i=1.
REQ-025 rdy_o = (state==RUN) and (fil < DATA_WD); it is registered-state based only, with no combinational path from val_i or rdy_i.
REQ-026 FSM states: RUN (normal packing), FLSH (draining a flushed stream).
REQ-027 RUN -> FLSH on accept with flush_i=1.
REQ-028 FLSH -> RUN when the word carrying last_o=1 transfers.
REQ-029 In FLSH, rdy_o SHALL be 0.
REQ-030 In FLSH, the remaining bits are zero-padded to the next byte boundary, and full words are emitted per REQ-020.
REQ-031 In FLSH, the final word carries last_o=1 and byte_o = ceil(fil/8) mod (DATA_WD/8).
REQ-032 If the flushing accept leaves fil == DATA_WD exactly, that word is the last word, with byte_o=0.
REQ-033 If the flushing accept leaves fil == 0 after emission, the most recently emitted word is marked last_o=1 instead, with byte_o=0.
REQ-034 Every word except the final word of a flushed stream SHALL have last_o=0.
REQ-035 Bits of acc above fil SHALL be zero at all times, so padding is zeros.
REQ-036 After FLSH -> RUN, fil=0 and acc=0; the next stream starts at bit 0.

Reset
REQ-037 When rst=1 at a clock edge: val_o=0, dat_o=0, last_o=0, byte_o=0, acc=0, fil=0, state=RUN, and rdy_o=1 in the following cycle.
REQ-038 Reset applies mid-stream or mid-flush; pending bits and the held output word are discarded with no partial emission.

Verification
REQ-039 DATA_WD=32, rdy_i=1; four 8-bit fragments 0x11, 0x22, 0x33, 0x44 -> one word dat_o=0x44332211, val_o=1 one cycle after the 4th accept, last_o=0.
REQ-040 numb_i=0, dat_i=0xDEADBEEF on 8 consecutive cycles, rdy_i=1 -> 8 consecutive words 0xDEADBEEF, and rdy_o never deasserts.
REQ-041 3-bit fragment 0b101 with flush_i=1 -> single word 0x00000005, last_o=1, byte_o=1, then rdy_o=1 again.
REQ-042 20-bit 0xABCDE, then 20-bit 0x12345 with flush_i=1 -> words 0x345ABCDE (last_o=0), then 0x00000012 (last_o=1, byte_o=1).
REQ-043 rdy_i held 0 for 10 cycles while driving full-width fragments -> dat_o stable, rdy_o drops to 0 once fil >= 32, and all words arrive in order with none lost once rdy_i=1.
REQ-044 rst asserted while in FLSH with val_o=1 -> next cycle val_o=0 and rdy_o=1, and a following 8-bit flushed fragment 0xA5 emits 0x000000A5 with byte_o=1.
